// File: rtl/dqs_tx_seq.sv
// DQS write-strobe sequencer: drives data/tristate of the DQS output buffer
// through preamble, toggling burst and postamble, with seamless burst chaining.
module dqs_tx_seq #(
    parameter int BURST_LEN = 8,
    parameter int PRE_LEN   = 2,
    parameter int POST_LEN  = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic             dqs_d,
    output logic             dqs_t,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] burst_count
);
    localparam int MAX_PB  = (PRE_LEN > BURST_LEN) ? PRE_LEN : BURST_LEN;
    localparam int MAX_LEN = (MAX_PB > POST_LEN) ? MAX_PB : POST_LEN;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] POST_LAST  = CW'(POST_LEN - 1);

    if (BURST_LEN < 2 || (BURST_LEN % 2) != 0) begin : g_bad_burst
        $error("dqs_tx_seq: BURST_LEN must be even and >= 2");
    end
    if (PRE_LEN < 1) begin : g_bad_pre
        $error("dqs_tx_seq: PRE_LEN must be >= 1");
    end
    if (POST_LEN < 1) begin : g_bad_post
        $error("dqs_tx_seq: POST_LEN must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("dqs_tx_seq: CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          burst_last;
    logic          post_last;
    logic          dqs_d_nx;
    logic          dqs_t_nx;

    assign burst_last = (state == BURST) && (cnt == BURST_LAST);
    assign post_last  = (state == POST) && (cnt == POST_LAST);
    assign ready      = (state == IDLE) || burst_last;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = PRE;
            end
            PRE: begin
                if (cnt == PRE_LAST) begin
                    state_nx = BURST;
                    cnt_nx   = '0;
                end
            end
            BURST: begin
                if (burst_last) begin
                    state_nx = start ? BURST : POST;
                    cnt_nx   = '0;
                end
            end
            POST: begin
                if (post_last) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        // Outputs are registered from the next state so each pin change lands
        // in the same cycle the state is entered.
        dqs_t_nx = (state_nx == IDLE);
        dqs_d_nx = (state_nx == BURST) && !cnt_nx[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dqs_d       <= 1'b0;
            dqs_t       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            burst_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dqs_d <= dqs_d_nx;
            dqs_t <= dqs_t_nx;
            busy  <= (state_nx != IDLE);
            done  <= post_last;
            if (burst_last) burst_count <= burst_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_dqs_tx_seq.sv
// Bench for dqs_tx_seq: vector tables, hand-written corner sequences and a
// randomized run against a waveform-queue reference model.
module tb_dqs_tx_seq;
    localparam int BL = 8;
    localparam int PL = 2;
    localparam int QL = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, start0 = 1'b0, ready0, d0, t0, busy0, done0;
    logic [7:0] bc0;
    logic       rst1 = 1'b1, start1 = 1'b0, ready1, d1, t1, busy1, done1;
    logic [1:0] bc1;
    logic       rst2 = 1'b1, start2 = 1'b0, ready2, d2, t2, busy2, done2;
    logic [7:0] bc2;

    dqs_tx_seq u0 (
        .clk(clk), .rst(rst0), .start(start0), .ready(ready0), .dqs_d(d0),
        .dqs_t(t0), .busy(busy0), .done(done0), .burst_count(bc0)
    );
    dqs_tx_seq #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .ready(ready1), .dqs_d(d1),
        .dqs_t(t1), .busy(busy1), .done(done1), .burst_count(bc1)
    );
    dqs_tx_seq #(.PRE_LEN(1), .BURST_LEN(4), .POST_LEN(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .ready(ready2), .dqs_d(d2),
        .dqs_t(t2), .busy(busy2), .done(done2), .burst_count(bc2)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset0();
        rst0 = 1'b1; start0 = 1'b0;
        tick();
        rst0 = 1'b0;
    endtask

    typedef struct {
        logic start;
        logic t;
        logic d;
        logic done;
        int   cnt;
    } vec_t;
    vec_t tbl[28];

    // Reference model: the future waveform as a queue of bit-times.
    typedef struct packed {
        logic t;
        logic d;
        logic last;
        logic post;
    } ent_t;
    localparam ent_t IDLE_E = '{t: 1'b1, d: 1'b0, last: 1'b0, post: 1'b0};
    ent_t       q[$];
    ent_t       cur;
    logic       m_done;
    logic [7:0] m_cnt;

    task automatic model_reset();
        q.delete();
        cur = IDLE_E; m_done = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step(input logic s, input logic r);
        ent_t nxt;
        if (r) begin
            model_reset();
            return;
        end
        if (s && (cur.t || cur.last)) begin
            if (cur.last) q.delete();
            else for (int i = 0; i < PL; i++) q.push_back('{t: 1'b0, d: 1'b0, last: 1'b0, post: 1'b0});
            for (int i = 0; i < BL; i++)
                q.push_back('{t: 1'b0, d: (i % 2 == 0), last: (i == BL - 1), post: 1'b0});
            for (int i = 0; i < QL; i++) q.push_back('{t: 1'b0, d: 1'b0, last: 1'b0, post: 1'b1});
        end
        nxt = (q.size() != 0) ? q.pop_front() : IDLE_E;
        m_done = cur.post && nxt.t;
        m_cnt  = m_cnt + 8'(cur.last);
        cur    = nxt;
    endtask

    logic exp_d2[9] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    logic exp_t2[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        // Single burst (rows 0-13) and the same burst with start held (rows 14-27).
        for (int c = 0; c < 14; c++) begin
            tbl[c].start = (c == 0);
            tbl[c].t     = !(c >= 1 && c <= 11);
            tbl[c].d     = (c >= 3 && c <= 10) && ((c - 3) % 2 == 0);
            tbl[c].done  = (c == 12);
            tbl[c].cnt   = (c >= 11) ? 1 : 0;
            tbl[c + 14]       = tbl[c];
            tbl[c + 14].start = (c <= 9);
        end

        tick(); tick();
        rst1 = 1'b0; rst2 = 1'b0;

        for (int i = 0; i < 28; i++) begin
            if (i % 14 == 0) begin
                reset0();
                chk("reset_busy", busy0, 0);
                chk("reset_ready", ready0, 1);
            end
            chk($sformatf("tbl%0d_t", i), t0, tbl[i].t);
            chk($sformatf("tbl%0d_d", i), d0, tbl[i].d);
            chk($sformatf("tbl%0d_done", i), done0, tbl[i].done);
            chk($sformatf("tbl%0d_cnt", i), bc0, tbl[i].cnt);
            chk($sformatf("tbl%0d_busy", i), busy0, !tbl[i].t);
            start0 = tbl[i].start;
            tick();
        end
        start0 = 1'b0;

        // Seamless chain.
        reset0();
        for (int c = 0; c < 22; c++) begin
            chk($sformatf("seam%0d_t", c), t0, !(c >= 1 && c <= 19));
            chk($sformatf("seam%0d_d", c), d0,
                ((c >= 3 && c <= 10) && ((c - 3) % 2 == 0)) ||
                ((c >= 11 && c <= 18) && ((c - 11) % 2 == 0)));
            chk($sformatf("seam%0d_done", c), done0, c == 20);
            if (c == 10) chk("seam_ready", ready0, 1);
            if (c == 20) chk("seam_cnt", bc0, 2);
            start0 = (c == 0 || c == 10);
            tick();
        end
        start0 = 1'b0;

        // Reset in the middle of a second burst.
        reset0();
        for (int c = 0; c < 14; c++) begin
            start0 = (c == 0);
            tick();
        end
        chk("rstmid_pre_cnt", bc0, 1);
        for (int c = 0; c < 6; c++) begin
            start0 = (c == 0);
            rst0   = (c == 5);
            tick();
        end
        rst0 = 1'b0; start0 = 1'b0;
        chk("rstmid_t", t0, 1);
        chk("rstmid_d", d0, 0);
        chk("rstmid_busy", busy0, 0);
        chk("rstmid_done", done0, 0);
        chk("rstmid_cnt", bc0, 0);
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("rstmid_pre0_t", t0, 0);
        chk("rstmid_pre0_d", d0, 0);
        tick();
        chk("rstmid_pre1_t", t0, 0);
        chk("rstmid_pre1_d", d0, 0);
        tick();
        chk("rstmid_burst_d", d0, 1);
        chk("rstmid_done2", done0, 0);

        // Counter wrap with a 2-bit counter.
        for (int b = 0; b < 4; b++) begin
            int k;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            for (k = 0; k < 20 && !done1; k++) tick();
            chk($sformatf("wrap%0d_timeout", b), done1, 1);
            chk($sformatf("wrap%0d_cnt", b), bc1, (b + 1) % 4);
        end

        // Short preamble, short burst, long postamble.
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("p6_%0d_t", c), t2, exp_t2[c]);
            chk($sformatf("p6_%0d_d", c), d2, exp_d2[c]);
            chk($sformatf("p6_%0d_done", c), done2, c == 8);
            start2 = (c == 0);
            tick();
        end
        chk("p6_cnt", bc2, 1);

        // Randomized run against the model.
        reset0();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic s, r;
            chk("rnd_t", t0, cur.t);
            chk("rnd_d", d0, cur.d);
            chk("rnd_busy", busy0, !cur.t);
            chk("rnd_done", done0, m_done);
            chk("rnd_cnt", bc0, m_cnt);
            chk("rnd_ready", ready0, cur.t || cur.last);
            s = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 249) == 0);
            start0 = s; rst0 = r;
            model_step(s, r);
            tick();
        end
        start0 = 1'b0; rst0 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
